// File: rtl/timer_pkg.sv
// Shared definitions for the two-digit BCD up/down timer: state encoding,
// display codes and small BCD helpers.
package timer_pkg;

  // FSM state encoding, also driven straight onto the status LEDs.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_HOLD  = 2'b10,
    ST_ALARM = 2'b11
  } state_t;

  // Hexdigit decoder code that turns a digit off.
  localparam logic [4:0] BLANK = 5'd20;

  // Largest legal value of one BCD digit.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // True when a nibble holds a decimal digit (0-9).
  function automatic logic digit_is_bcd(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

  // True when both nibbles of a {tens, ones} byte are decimal digits.
  function automatic logic byte_is_bcd(input logic [7:0] b);
    return digit_is_bcd(b[7:4]) && digit_is_bcd(b[3:0]);
  endfunction

  // Widen a BCD digit to the 5-bit hexdigit input code.
  function automatic logic [4:0] digit_code(input logic [3:0] d);
    return {1'b0, d};
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit stepper: increments or decrements a single decimal digit
// and reports the carry (9 -> 0 going up) or borrow (0 -> 9 going down)
// into the next more significant digit. A non-decimal input is forced to 0
// and never produces a carry or borrow, so a corrupted digit heals itself
// on the next step.
module bcd_digit_step
  import timer_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       en,
  input  logic       up,
  output logic [3:0] next,
  output logic       carry_borrow
);

  // Next digit value and carry/borrow out for one step in either direction.
  always_comb begin
    next         = digit;
    carry_borrow = 1'b0;
    if (!digit_is_bcd(digit)) begin
      next = 4'd0;
    end else if (en) begin
      if (up) begin
        if (digit == BCD_MAX) begin
          next         = 4'd0;
          carry_borrow = 1'b1;
        end else begin
          next = digit + 4'd1;
        end
      end else begin
        if (digit == 4'd0) begin
          next         = BCD_MAX;
          carry_borrow = 1'b1;
        end else begin
          next = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD up/down timer (00-99) stepped by the 1 Hz clock.
// Slide switches select run/pause, direction, reload and display blanking.
// Counting down to 00 raises an alarm that blinks the display until it is
// acknowledged (start=0) or times out after ALARM_LEN edges, after which
// the timer reloads PRESET and waits in IDLE.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter logic [7:0] PRESET    = 8'h30,
  parameter logic [3:0] ALARM_LEN = 4'd10
) (
  input  logic       clk_1hz,
  input  logic       rst,
  input  logic       start,
  input  logic       up,
  input  logic       load,
  input  logic       hide,
  output logic [4:0] data_0,
  output logic [4:0] data_1,
  output logic [1:0] state_o,
  output logic       done
);

  state_t     state;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       blink;
  logic [3:0] alarm_cnt;

  logic       step_en;
  logic [3:0] ones_next;
  logic [3:0] tens_next;
  logic       ones_cb;
  logic       tens_cb;
  logic       at_one;
  logic       underflow;
  logic       alarm_exit;

  // A step happens only on an edge where the timer is already running and
  // start is still high; entering RUN from IDLE/HOLD never steps.
  assign step_en = (state == ST_RUN) && start;

  bcd_digit_step u_ones (
    .digit        (ones),
    .en           (step_en),
    .up           (up),
    .next         (ones_next),
    .carry_borrow (ones_cb)
  );

  bcd_digit_step u_tens (
    .digit        (tens),
    .en           (ones_cb),
    .up           (up),
    .next         (tens_next),
    .carry_borrow (tens_cb)
  );

  // Counting down: reaching 00 from 01 raises the alarm, and a borrow out of
  // the tens digit means we were already at 00 (e.g. PRESET=00), which also
  // alarms instead of wrapping to 99. Counting up, 99 wraps silently to 00.
  assign at_one     = (tens == 4'd0) && (ones == 4'd1);
  assign underflow  = !up && tens_cb;
  assign alarm_exit = !start || (alarm_cnt == (ALARM_LEN - 4'd1));

  // Timer FSM and BCD count register; reload has priority over everything.
  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      assert (byte_is_bcd(PRESET))
        else $error("PRESET must hold two BCD digits");
      assert (ALARM_LEN != 4'd0)
        else $error("ALARM_LEN must be 1-15");
      state     <= ST_IDLE;
      tens      <= PRESET[7:4];
      ones      <= PRESET[3:0];
      done      <= 1'b0;
      blink     <= 1'b0;
      alarm_cnt <= 4'd0;
    end else if (load) begin
      state     <= ST_IDLE;
      tens      <= PRESET[7:4];
      ones      <= PRESET[3:0];
      done      <= 1'b0;
      blink     <= 1'b0;
      alarm_cnt <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (!start) begin
            state <= ST_HOLD;
          end else if (!up && (at_one || underflow)) begin
            state     <= ST_ALARM;
            tens      <= 4'd0;
            ones      <= 4'd0;
            done      <= 1'b1;
            blink     <= 1'b0;
            alarm_cnt <= 4'd0;
          end else begin
            tens <= tens_next;
            ones <= ones_next;
          end
        end

        ST_HOLD: begin
          if (start) begin
            state <= ST_RUN;
          end
        end

        ST_ALARM: begin
          if (alarm_exit) begin
            state     <= ST_IDLE;
            tens      <= PRESET[7:4];
            ones      <= PRESET[3:0];
            done      <= 1'b0;
            blink     <= 1'b0;
            alarm_cnt <= 4'd0;
          end else begin
            blink     <= ~blink;
            alarm_cnt <= alarm_cnt + 4'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Display mux: blanking wins, the alarm flashes 00, otherwise show the count.
  always_comb begin
    data_0 = digit_code(ones);
    data_1 = digit_code(tens);
    if (hide) begin
      data_0 = BLANK;
      data_1 = BLANK;
    end else if (state == ST_ALARM) begin
      data_0 = blink ? BLANK : digit_code(4'd0);
      data_1 = blink ? BLANK : digit_code(4'd0);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed walk through the main scenarios
// with literal expectations, then randomized switch activity, all checked
// every cycle against a decimal-arithmetic model of the timer.
module tb_bcd_countdown_timer;

  localparam int PRE  = 30;
  localparam int ALEN = 10;
  localparam int BLK  = 20;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_HOLD  = 2;
  localparam int M_ALARM = 3;

  logic       clk_1hz = 1'b0;
  logic       rst;
  logic       start = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic       hide = 1'b0;
  logic [4:0] data_0;
  logic [4:0] data_1;
  logic [1:0] state_o;
  logic       done;

  int errors = 0;
  int checks = 0;

  // Model state: count as a plain integer, mode, edges spent in alarm.
  int m_val;
  int m_st;
  int m_age;

  bcd_countdown_timer #(.PRESET(8'h30), .ALARM_LEN(4'd10)) dut (
    .clk_1hz (clk_1hz),
    .rst     (rst),
    .start   (start),
    .up      (up),
    .load    (load),
    .hide    (hide),
    .data_0  (data_0),
    .data_1  (data_1),
    .state_o (state_o),
    .done    (done)
  );

  always #5 clk_1hz = ~clk_1hz;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nxt_st(int v, int st, int age, bit ld, bit s, bit u);
    if (ld) return M_IDLE;
    case (st)
      M_IDLE:  return s ? M_RUN : M_IDLE;
      M_RUN: begin
        if (!s) return M_HOLD;
        if (!u && v <= 1) return M_ALARM;
        return M_RUN;
      end
      M_HOLD:  return s ? M_RUN : M_HOLD;
      default: return (!s || age == ALEN - 1) ? M_IDLE : M_ALARM;
    endcase
  endfunction

  function automatic int nxt_val(int v, int st, int age, bit ld, bit s, bit u);
    if (ld) return PRE;
    if (st == M_RUN && s) begin
      if (u) return (v + 1) % 100;
      return (v <= 1) ? 0 : v - 1;
    end
    if (st == M_ALARM && (!s || age == ALEN - 1)) return PRE;
    return v;
  endfunction

  function automatic int nxt_age(int st, int age, bit ld, bit s);
    if (ld) return 0;
    if (st == M_ALARM && s && age != ALEN - 1) return age + 1;
    return 0;
  endfunction

  function automatic int exp_d0();
    if (hide) return BLK;
    if (m_st == M_ALARM) return (m_age % 2 == 1) ? BLK : 0;
    return m_val % 10;
  endfunction

  function automatic int exp_d1();
    if (hide) return BLK;
    if (m_st == M_ALARM) return (m_age % 2 == 1) ? BLK : 0;
    return m_val / 10;
  endfunction

  // Reference model, advanced by the same edges as the DUT.
  always @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      m_val <= PRE;
      m_st  <= M_IDLE;
      m_age <= 0;
    end else begin
      m_val <= nxt_val(m_val, m_st, m_age, load, start, up);
      m_st  <= nxt_st(m_val, m_st, m_age, load, start, up);
      m_age <= nxt_age(m_st, m_age, load, start);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_1hz) begin
    check("model data_0", int'(data_0), exp_d0());
    check("model data_1", int'(data_1), exp_d1());
    check("model state_o", int'(state_o), m_st);
    check("model done", int'(done), (m_st == M_ALARM) ? 1 : 0);
  end

  // Advance one edge; returns 2 time units after the following falling edge.
  task automatic step();
    @(posedge clk_1hz);
    @(negedge clk_1hz);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_out(input string name, input int d1, input int d0,
                            input int st, input int dn);
    check({name, " tens"}, int'(data_1), d1);
    check({name, " ones"}, int'(data_0), d0);
    check({name, " state"}, int'(state_o), st);
    check({name, " done"}, int'(done), dn);
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    expect_out("reset", 3, 0, M_IDLE, 0);
    hide = 1'b1;
    #1;
    expect_out("reset hidden", BLK, BLK, M_IDLE, 0);
    hide  = 1'b0;
    start = 1'b1;
    up    = 1'b0;
    rst   = 1'b1;

    // Count down from PRESET: first edge only enters RUN.
    step(); expect_out("down e1", 3, 0, M_RUN, 0);
    step(); expect_out("down e2", 2, 9, M_RUN, 0);
    step(); expect_out("down e3", 2, 8, M_RUN, 0);

    // Run down to the alarm, blink for ALARM_LEN edges, then auto-return.
    steps(26); expect_out("at 02", 0, 2, M_RUN, 0);
    step(); expect_out("at 01", 0, 1, M_RUN, 0);
    step(); expect_out("alarm entry", 0, 0, M_ALARM, 1);
    for (int k = 1; k < 10; k++) begin
      step();
      if (k % 2 == 1) expect_out("alarm blank", BLK, BLK, M_ALARM, 1);
      else            expect_out("alarm zero", 0, 0, M_ALARM, 1);
    end
    step(); expect_out("alarm timeout", 3, 0, M_IDLE, 0);

    // Count up across the 99 -> 00 wrap.
    up = 1'b1;
    step(); expect_out("up enter", 3, 0, M_RUN, 0);
    steps(68); expect_out("up 98", 9, 8, M_RUN, 0);
    step(); expect_out("up 99", 9, 9, M_RUN, 0);
    step(); expect_out("up wrap 00", 0, 0, M_RUN, 0);
    step(); expect_out("up 01", 0, 1, M_RUN, 0);

    // Pause at 15, resume, then step down.
    steps(14); expect_out("up 15", 1, 5, M_RUN, 0);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); expect_out("hold 15", 1, 5, M_HOLD, 0);
    end
    start = 1'b1;
    step(); expect_out("resume 15", 1, 5, M_RUN, 0);
    up = 1'b0;
    step(); expect_out("resume 14", 1, 4, M_RUN, 0);

    // Acknowledge the alarm on its fourth edge.
    steps(14); expect_out("alarm again", 0, 0, M_ALARM, 1);
    steps(3);  expect_out("alarm age3", BLK, BLK, M_ALARM, 1);
    start = 1'b0;
    step(); expect_out("alarm ack", 3, 0, M_IDLE, 0);

    // Reset mid-RUN at 21 takes effect without a clock edge.
    start = 1'b1;
    step(); steps(9); expect_out("run 21", 2, 1, M_RUN, 0);
    rst = 1'b0;
    #1 expect_out("async reset", 3, 0, M_IDLE, 0);
    rst = 1'b1;

    // Blanking does not stop the count.
    step(); expect_out("rerun 30", 3, 0, M_RUN, 0);
    hide = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(); expect_out("hidden", BLK, BLK, M_RUN, 0);
    end
    hide = 1'b0;
    #1 expect_out("unhide 25", 2, 5, M_RUN, 0);

    // Randomized switch activity; the model process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 7) != 0);
      up    = $urandom_range(0, 1);
      load  = ($urandom_range(0, 40) == 0);
      hide  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 250) == 0) begin
        rst = 1'b0;
        #1 rst = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
